alu_unit: RTL and testbench

- Registered 8-bit signed ALU with two operation sets, selected by the operand-group enables a_en and b_en.
- The result appears on C one clock after the inputs are sampled.
- The ALU_en input gates the result register.
- Standalone leaf datapath block, driven from a single-clock test/system interface.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_opsel.sv | 74 +++++++
 rtl/alu_unit.sv | 50 +++++
 tb/tb_alu_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: operand width and opcode enumerations.
package alu_pkg;

  localparam int unsigned WIDTH = 8;

  // Opcodes used when a_en=1, b_en=0.
  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    XOR    = 3'd2,
    AND1   = 3'd3,
    AND2   = 3'd4,
    OR     = 3'd5,
    XNOR   = 3'd6,
    NULL_A = 3'd7
  } a_op_e;

  // Opcodes used when a_en=0, b_en=1.
  typedef enum logic [1:0] {
    NAND   = 2'd0,
    ADD1   = 2'd1,
    ADD2   = 2'd2,
    NULL_B = 2'd3
  } b_op1_e;

  // Opcodes used when a_en=1, b_en=1.
  typedef enum logic [1:0] {
    XOR_B  = 2'd0,
    XNOR_B = 2'd1,
    INC_A  = 2'd2,
    ADD2_B = 2'd3
  } b_op2_e;

endpackage

// File: rtl/alu_opsel.sv
// Combinational operation select for alu_unit.
// Ports:
//   a_en, b_en   : operation-group select
//   a_op, b_op   : opcodes for the selected group
//   A, B         : two's complement operands
//   o_result_c   : next result value (meaningful only when o_hold_c=0)
//   o_hold_c     : 1 when the selected operation is a NULL (result register holds)
module alu_opsel
  import alu_pkg::*;
(
  input  logic                    a_en,
  input  logic                    b_en,
  input  logic [2:0]              a_op,
  input  logic [1:0]              b_op,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH-1:0] o_result_c,
  output logic                    o_hold_c
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  // Truncating adders/subtractor: overflow wraps with no flag.
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_inc_a;
  logic [WIDTH-1:0] w_add2_b;

  assign w_sum    = WIDTH'(A + B);
  assign w_diff   = WIDTH'(A - B);
  assign w_inc_a  = WIDTH'(A + ONE);
  assign w_add2_b = WIDTH'(B + TWO);

  // Group decode; any unmatched selection holds the result.
  always_comb begin
    o_result_c = '0;
    o_hold_c   = 1'b1;
    unique case ({a_en, b_en})
      2'b10: begin
        o_hold_c = 1'b0;
        case (a_op_e'(a_op))
          ADD:        o_result_c = w_sum;
          SUB:        o_result_c = w_diff;
          XOR:        o_result_c = A ^ B;
          AND1, AND2: o_result_c = A & B;
          OR:         o_result_c = A | B;
          XNOR:       o_result_c = ~(A ^ B);
          default:    o_hold_c   = 1'b1;
        endcase
      end
      2'b01: begin
        o_hold_c = 1'b0;
        case (b_op1_e'(b_op))
          NAND:       o_result_c = ~(A & B);
          ADD1, ADD2: o_result_c = w_sum;
          default:    o_hold_c   = 1'b1;
        endcase
      end
      2'b11: begin
        o_hold_c = 1'b0;
        case (b_op2_e'(b_op))
          XOR_B:   o_result_c = A ^ B;
          XNOR_B:  o_result_c = ~(A ^ B);
          INC_A:   o_result_c = w_inc_a;
          ADD2_B:  o_result_c = w_add2_b;
          default: o_hold_c   = 1'b1;
        endcase
      end
      default: o_hold_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Registered 8-bit signed ALU; C updates one clock after inputs are sampled.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (C forced to 0)
//   ALU_en       : result-register enable; 0 holds C
//   a_en, b_en   : operation-group select
//   a_op, b_op   : opcodes
//   A, B         : signed operands
//   C            : signed registered result
module alu_unit
  import alu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ALU_en,
  input  logic                    a_en,
  input  logic                    b_en,
  input  logic [2:0]              a_op,
  input  logic [1:0]              b_op,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  output logic signed [WIDTH-1:0] C
);

  logic signed [WIDTH-1:0] w_next;
  logic                    w_hold;
  logic signed [WIDTH-1:0] r_c;

  alu_opsel u_opsel (
    .a_en       (a_en),
    .b_en       (b_en),
    .a_op       (a_op),
    .b_op       (b_op),
    .A          (A),
    .B          (B),
    .o_result_c (w_next),
    .o_hold_c   (w_hold)
  );

  // Result register: loads only when enabled and the operation is not NULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c <= '0;
    end else if (ALU_en && !w_hold) begin
      r_c <= w_next;
    end
  end

  assign C = r_c;

endmodule

// File: tb/tb_alu_unit.sv
// Directed, table-driven bench for alu_unit.
module tb_alu_unit;

  logic              clk;
  logic              rst_n;
  logic              ALU_en;
  logic              a_en;
  logic              b_en;
  logic [2:0]        a_op;
  logic [1:0]        b_op;
  logic signed [7:0] A;
  logic signed [7:0] B;
  logic signed [7:0] C;

  int n_checks;
  int n_fail;

  typedef struct {
    logic       alu_en;
    logic       a_en;
    logic       b_en;
    logic [2:0] a_op;
    logic [1:0] b_op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ALU_en (ALU_en),
    .a_en   (a_en),
    .b_en   (b_en),
    .a_op   (a_op),
    .b_op   (b_op),
    .A      (A),
    .B      (B),
    .C      (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic ae, input logic be,
                       input logic [2:0] ao, input logic [1:0] bo,
                       input logic [7:0] a, input logic [7:0] b);
    ALU_en = en; a_en = ae; b_en = be; a_op = ao; b_op = bo;
    A = a; B = b;
  endtask

  function automatic vec_t mk(input logic en, input logic ae, input logic be,
                              input logic [2:0] ao, input logic [1:0] bo,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] e);
    vec_t v;
    v.alu_en = en; v.a_en = ae; v.b_en = be; v.a_op = ao; v.b_op = bo;
    v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Set a sweep: A=100, B=27
    vecs.push_back(mk(1, 1, 0, 3'd0, 2'd0, 8'd100, 8'd27, 8'h7F));
    vecs.push_back(mk(1, 1, 0, 3'd1, 2'd0, 8'd100, 8'd27, 8'h49));
    vecs.push_back(mk(1, 1, 0, 3'd2, 2'd0, 8'd100, 8'd27, 8'h7F));
    vecs.push_back(mk(1, 1, 0, 3'd3, 2'd0, 8'd100, 8'd27, 8'h00));
    vecs.push_back(mk(1, 1, 0, 3'd4, 2'd0, 8'd100, 8'd27, 8'h00));
    vecs.push_back(mk(1, 1, 0, 3'd5, 2'd0, 8'd100, 8'd27, 8'h7F));
    vecs.push_back(mk(1, 1, 0, 3'd6, 2'd0, 8'd100, 8'd27, 8'h80));
    vecs.push_back(mk(1, 1, 0, 3'd7, 2'd0, 8'd100, 8'd27, 8'h80));
    // ALU_en=0 holds for several cycles
    vecs.push_back(mk(0, 1, 0, 3'd0, 2'd0, 8'd1,   8'd1,  8'h80));
    vecs.push_back(mk(0, 0, 1, 3'd0, 2'd2, 8'd5,   8'd9,  8'h80));
    // {a_en,b_en}=00 holds
    vecs.push_back(mk(1, 0, 0, 3'd0, 2'd1, 8'd3,   8'd4,  8'h80));
    // Set 1: A=F0, B=3C
    vecs.push_back(mk(1, 0, 1, 3'd0, 2'd0, 8'hF0, 8'h3C, 8'hCF));
    vecs.push_back(mk(1, 0, 1, 3'd0, 2'd3, 8'hF0, 8'h3C, 8'hCF));
    vecs.push_back(mk(1, 0, 1, 3'd0, 2'd1, 8'hF0, 8'h3C, 8'h2C));
    vecs.push_back(mk(1, 0, 1, 3'd0, 2'd0, 8'hF0, 8'h3C, 8'hCF));
    vecs.push_back(mk(1, 0, 1, 3'd7, 2'd2, 8'hF0, 8'h3C, 8'h2C));
    vecs.push_back(mk(1, 0, 1, 3'd0, 2'd3, 8'hF0, 8'h3C, 8'h2C));
    // Set 2: A=0F, B=7E (a_op must be ignored)
    vecs.push_back(mk(1, 1, 1, 3'd7, 2'd0, 8'h0F, 8'h7E, 8'h71));
    vecs.push_back(mk(1, 1, 1, 3'd7, 2'd1, 8'h0F, 8'h7E, 8'h8E));
    vecs.push_back(mk(1, 1, 1, 3'd0, 2'd2, 8'h0F, 8'h7E, 8'h10));
    vecs.push_back(mk(1, 1, 1, 3'd1, 2'd3, 8'h0F, 8'h7E, 8'h80));
    // Wrap-around
    vecs.push_back(mk(1, 1, 0, 3'd0, 2'd0, 8'h7F, 8'h01, 8'h80));
    vecs.push_back(mk(1, 1, 0, 3'd1, 2'd0, 8'h80, 8'h01, 8'h7F));
    // b_op ignored when b_en=0: a_op=7 holds even with b_op=0
    vecs.push_back(mk(1, 1, 0, 3'd7, 2'd0, 8'h11, 8'h22, 8'h7F));
    vecs.push_back(mk(0, 0, 1, 3'd0, 2'd0, 8'h11, 8'h22, 8'h7F));

    // Reset state
    rst_n = 1'b0;
    drive(1, 1, 0, 3'd0, 2'd0, 8'd5, 8'd3);
    @(posedge clk); #1;
    check("reset_init", C, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_add", C, 8'h08);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", C, 8'h00);
    @(posedge clk); #1;
    check("reset_held", C, 8'h00);

    // After release, C stays 0 until an enabled update
    @(negedge clk);
    rst_n = 1'b1;
    ALU_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post_reset_hold", C, 8'h00);

    // Pending result discarded by reset before the edge
    @(negedge clk);
    drive(1, 1, 0, 3'd0, 2'd0, 8'd20, 8'd22);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("pending_discard", C, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_discard", C, 8'd42);

    // Table sweep
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].alu_en, vecs[i].a_en, vecs[i].b_en, vecs[i].a_op,
            vecs[i].b_op, vecs[i].a, vecs[i].b);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), C, vecs[i].exp);
    end

    // Multi-cycle hold with ALU_en=0 and changing operands
    @(negedge clk);
    drive(0, 1, 1, 3'd0, 2'd2, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      A = 8'(k * 37);
      B = 8'(k + 9);
      @(posedge clk); #1;
      check($sformatf("hold_cycle%0d", k), C, 8'h7F);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
